// File: rtl/rv32_mem_responder.sv
// Word-addressed memory with two request ports (fetch and data), round-robin arbitration
// and a fixed number of wait states before each one-cycle response strobe.
module rv32_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out
);

  localparam int unsigned DEPTH = 1 << ADDR_WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state, next_state;
  logic [3:0]                 cnt;
  logic                       last_data;
  logic                       lat_data;
  logic                       lat_write;
  logic [ADDR_WORDS_LOG2-1:0] lat_idx;
  logic [3:0]                 lat_mask;
  logic [31:0]                lat_wdata;
  logic [31:0]                mem [DEPTH];

  logic                       instr_req, data_req, any_req, grant_data;
  logic                       resp_data_next, enter_resp;
  logic [ADDR_WORDS_LOG2-1:0] grant_idx, rd_idx;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^{instr_address_in[31:ADDR_WORDS_LOG2+2], instr_address_in[1:0],
                              data_address_in[31:ADDR_WORDS_LOG2+2], data_address_in[1:0]};

  // Arbitration: when both ports ask, the one not served last wins; reset favours data.
  always_comb begin
    instr_req  = instr_read_in;
    data_req   = data_read_in | data_write_in;
    any_req    = instr_req | data_req;
    grant_data = data_req & (~instr_req | ~last_data);
    grant_idx  = grant_data ? data_address_in[ADDR_WORDS_LOG2+1:2]
                            : instr_address_in[ADDR_WORDS_LOG2+1:2];
    rd_idx         = (state == IDLE) ? grant_idx  : lat_idx;
    resp_data_next = (state == IDLE) ? grant_data : lat_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt <= 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP) && (state != RESP);
  end

  always_comb begin
    instr_ready_out = (state == RESP) && !lat_data;
    data_ready_out  = (state == RESP) &&  lat_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt                  <= '0;
      last_data            <= 1'b0;
      lat_data             <= 1'b0;
      lat_write            <= 1'b0;
      lat_idx              <= '0;
      lat_mask             <= '0;
      lat_wdata            <= '0;
      instr_read_value_out <= '0;
      data_read_value_out  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_data  <= grant_data;
        last_data <= grant_data;
        lat_idx   <= grant_idx;
        lat_write <= grant_data & data_write_in;
        lat_mask  <= data_write_mask_in;
        lat_wdata <= data_write_value_in;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // Read value captures the pre-write word, since the store lands at the end of RESP.
      if (enter_resp) begin
        if (resp_data_next) data_read_value_out  <= mem[rd_idx];
        else                instr_read_value_out <= mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && lat_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lat_mask[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule
